// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial feeder for the sequence-detector stage: valid/ready load, one bit per clk on x_out.
// Optional even-parity trailer bit is enabled by defining SERIALIZER_PARITY_EN.
module fsm_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_n;
    logic [WIDTH-1:0] shifted;
    logic             x_out_n;
    logic             first_bit;
    logic             next_bit;
    logic             last;
    logic             accept;
`ifdef SERIALIZER_PARITY_EN
    logic             par_bit;
    logic             par_n;
`endif

    // The shift register keeps the bit currently on x_out at its output end.
    assign shifted   = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
    assign next_bit  = (MSB_FIRST != 0) ? shifted[WIDTH-1] : shifted[0];
    assign first_bit = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];

    assign last = (state == SHIFT) && (cnt == LAST_IDX);

    // Ready and done decode registered state only, so ready never depends on load_valid.
`ifdef SERIALIZER_PARITY_EN
    assign load_ready = (state == IDLE) || (state == PAR);
    assign done       = (state == PAR);
`else
    assign load_ready = (state == IDLE) || last;
    assign done       = last;
`endif

    assign accept = load_valid && load_ready;

    // State register and registered datapath/outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sreg    <= sreg_n;
            x_out   <= x_out_n;
            x_valid <= (state_n != IDLE);
            busy    <= (state_n != IDLE);
`ifdef SERIALIZER_PARITY_EN
            par_bit <= par_n;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) state_n = SHIFT;
            end
            SHIFT: begin
                if (cnt == LAST_IDX) begin
`ifdef SERIALIZER_PARITY_EN
                    state_n = PAR;
`else
                    state_n = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
                state_n = accept ? SHIFT : IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Datapath next values; a reload always wins so back-to-back frames stay gapless
    always_comb begin
        sreg_n  = sreg;
        cnt_n   = cnt;
        x_out_n = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_n   = par_bit;
`endif
        if (accept) begin
            sreg_n  = data_in;
            cnt_n   = '0;
            x_out_n = first_bit;
`ifdef SERIALIZER_PARITY_EN
            par_n   = ^data_in;
`endif
        end else if ((state == SHIFT) && (cnt != LAST_IDX)) begin
            sreg_n  = shifted;
            cnt_n   = cnt + CW'(1);
            x_out_n = next_bit;
`ifdef SERIALIZER_PARITY_EN
        end else if (state == SHIFT) begin
            sreg_n  = '0;
            cnt_n   = '0;
            x_out_n = par_bit;
`endif
        end else begin
            sreg_n  = '0;
            cnt_n   = '0;
        end
    end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer: an MSB-first and an LSB-first instance share the same stimulus.
// Frame length follows SERIALIZER_PARITY_EN when that macro is defined.
module tb_fsm_bit_serializer;

    localparam int unsigned W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready, x_out, x_valid, busy, done;
    logic         load_ready_l, x_out_l, x_valid_l, busy_l, done_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
    );

    fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready_l), .x_out(x_out_l), .x_valid(x_valid_l), .busy(busy_l), .done(done_l)
    );

    // Bit idx of a frame: data bits in send order, then the parity bit at idx W.
    function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
        if (idx >= int'(W)) return ^w;
        return msb ? w[W-1-idx] : w[idx];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b1; data_in = 8'hB2;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({x_out, x_valid, busy, done, load_ready} !== 5'b00001 ||
                {x_out_l, x_valid_l, busy_l, done_l, load_ready_l} !== 5'b00001) begin
                errors++;
                $display("FAIL reset got msb=%b lsb=%b want 00001", {x_out, x_valid, busy, done, load_ready},
                         {x_out_l, x_valid_l, busy_l, done_l, load_ready_l});
            end
        end
        load_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({x_valid, busy, done, x_valid_l} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release got %b want 0000", {x_valid, busy, done, x_valid_l});
        end
    endtask

    task automatic test_single(input logic [W-1:0] word, input string tag);
        logic [4:0] e;
        load_valid = 1'b1; data_in = word;
        @(posedge clk); #1;
        load_valid = 1'b0; data_in = ~word;
        for (int k = 1; k <= int'(FL); k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            e = {exp_bit(word, k-1, 1'b1), 1'b1, 1'b1, k == int'(FL), k == int'(FL)};
            checks++;
            if ({x_out, x_valid, busy, done, load_ready} !== e) begin
                errors++;
                $display("FAIL %s_msb cycle %0d got %b want %b", tag, k, {x_out, x_valid, busy, done, load_ready}, e);
            end
            e[4] = exp_bit(word, k-1, 1'b0);
            checks++;
            if ({x_out_l, x_valid_l, busy_l, done_l, load_ready_l} !== e) begin
                errors++;
                $display("FAIL %s_lsb cycle %0d got %b want %b", tag, k,
                         {x_out_l, x_valid_l, busy_l, done_l, load_ready_l}, e);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({x_out, x_valid, busy, done, x_valid_l, busy_l} !== 6'b000000) begin
            errors++;
            $display("FAIL %s_end got %b want 000000", tag, {x_out, x_valid, busy, done, x_valid_l, busy_l});
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]   e;
        logic [W-1:0] word;
        bit           last;
        load_valid = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        data_in = 8'h01;
        for (int k = 1; k <= 2 * int'(FL); k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            word = (k <= int'(FL)) ? 8'hFF : 8'h01;
            last = (k % int'(FL)) == 0;
            e = {exp_bit(word, (k-1) % int'(FL), 1'b1), 1'b1, 1'b1, last, last};
            checks++;
            if ({x_out, x_valid, busy, done, load_ready} !== e) begin
                errors++;
                $display("FAIL b2b_msb cycle %0d got %b want %b", k, {x_out, x_valid, busy, done, load_ready}, e);
            end
            e[4] = exp_bit(word, (k-1) % int'(FL), 1'b0);
            checks++;
            if ({x_out_l, x_valid_l, busy_l, done_l, load_ready_l} !== e) begin
                errors++;
                $display("FAIL b2b_lsb cycle %0d got %b want %b", k,
                         {x_out_l, x_valid_l, busy_l, done_l, load_ready_l}, e);
            end
            if (k == int'(FL) + 1) load_valid = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if ({x_valid, busy, x_valid_l} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_end got %b want 000", {x_valid, busy, x_valid_l});
        end
    endtask

    task automatic test_load_while_busy();
        logic [W-1:0] word = 8'hC3;
        logic [1:0]   e;
        load_valid = 1'b1; data_in = word;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int k = 1; k <= int'(FL); k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            e = {exp_bit(word, k-1, 1'b1), exp_bit(word, k-1, 1'b0)};
            checks++;
            if ({x_out, x_out_l} !== e || x_valid !== 1'b1) begin
                errors++;
                $display("FAIL busy_load cycle %0d got bits %b valid %b want bits %b valid 1", k,
                         {x_out, x_out_l}, x_valid, e);
            end
            if (k == 3) begin
                load_valid = 1'b1; data_in = 8'h00;
                checks++;
                if (load_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready got %b want 0", load_ready);
                end
            end
            if (k == 4) load_valid = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if ({x_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL busy_load_end got %b want 00", {x_valid, busy});
        end
    endtask

    task automatic test_reset_mid_frame();
        load_valid = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({x_out, x_valid, busy, done, x_out_l, x_valid_l, done_l} !== 7'b0000000) begin
            errors++;
            $display("FAIL async_reset got %b want 0000000", {x_out, x_valid, busy, done, x_out_l, x_valid_l, done_l});
        end
        @(posedge clk); #1;
        checks++;
        if ({done, done_l, load_ready} !== 3'b001) begin
            errors++;
            $display("FAIL async_reset_hold got %b want 001", {done, done_l, load_ready});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_single(8'h0F, "after_reset");
    endtask

    initial begin
        load_valid = 1'b0;
        data_in    = '0;
        test_reset();
        test_single(8'hB2, "single");
        test_single(8'h07, "single07");
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
